// File: rtl/frame_generator.sv
// frame_generator: pops commands from a FWFT FIFO and streams Ethernet frames
// (header, clamped fill payload, no FCS) over AXI-Stream with a fixed inter-frame gap.
module frame_generator #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_SIZE   = 60,
    parameter int MAX_SIZE   = 1514
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rd_valid,
    output logic        fifo_rd_enable,
    input  logic [10:0] size,
    input  logic [47:0] d_mac,
    input  logic [47:0] s_mac,
    input  logic [15:0] ethertype,
    input  logic [7:0]  payload,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [31:0] frames_sent
);
    localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

    state_t        state, state_next;
    logic [10:0]   cnt, len;
    logic [127:0]  hdr;
    logic [7:0]    fill;
    logic [GW-1:0] gap;
    logic          hs, last;

    assign hs   = m_axis_tvalid & m_axis_tready;
    assign last = cnt == len - 11'd1;

    always_comb begin
        fifo_rd_enable = state == IDLE && fifo_rd_valid && !rst;
        m_axis_tvalid  = state == HEADER || state == PAYLOAD;
        m_axis_tdata   = state == HEADER  ? hdr[{cnt[3:0], 3'b000} +: 8] :
                         state == PAYLOAD ? fill : 8'd0;
        m_axis_tlast   = m_axis_tvalid && last;
        busy           = state != IDLE;
        state_next     = state;
        unique case (state)
            IDLE:    state_next = fifo_rd_enable ? HEADER : IDLE;
            HEADER:  state_next = hs && cnt == 11'd13 ? PAYLOAD : HEADER;
            PAYLOAD: state_next = hs && last ? (IFG_CYCLES > 0 ? GAP : IDLE) : PAYLOAD;
            GAP:     state_next = gap == '0 ? IDLE : GAP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            hdr         <= '0;
            fill        <= '0;
            gap         <= '0;
            frames_sent <= '0;
        end else begin
            state <= state_next;
            if (fifo_rd_enable) begin
                hdr  <= {16'd0, ethertype, s_mac, d_mac};
                fill <= payload;
                cnt  <= '0;
                // clamp once at pop time so the frame in flight ignores later size changes
                len  <= size < 11'(MIN_SIZE) ? 11'(MIN_SIZE) :
                        size > 11'(MAX_SIZE) ? 11'(MAX_SIZE) : size;
            end else if (hs) begin
                cnt <= cnt + 11'd1;
            end
            if (m_axis_tlast && hs) begin
                frames_sent <= frames_sent + 32'd1;
                gap         <= GW'(IFG_CYCLES - 1);
            end else if (state == GAP) begin
                gap <= gap - 1'b1;
            end
        end
    end
endmodule

// File: doc/frame_generator.md
FRAME_GENERATOR -- requirements
Module: frame_generator

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles inserted after each frame's last byte.
REQ-002 Parameter MIN_SIZE, default 60, minimum emitted frame length in bytes, excluding FCS.
REQ-003 Parameter MAX_SIZE, default 1514, maximum emitted frame length in bytes, excluding FCS.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 fifo_rd_valid  in  1  command FIFO non-empty; first-word-fall-through, command fields valid while high.
REQ-008 fifo_rd_enable  out  1  one-cycle pop strobe to the command FIFO.
REQ-009 size  in  11  requested frame length in bytes, header included, FCS excluded.
REQ-010 d_mac  in  48  destination MAC; bits [7:0] are the first byte on the wire.
REQ-011 s_mac  in  48  source MAC; bits [7:0] are the first byte on the wire.
REQ-012 ethertype  in  16  EtherType; bits [7:0] are the first byte on the wire.
REQ-013 payload  in  8  fill byte repeated for every payload position.
REQ-014 m_axis_tdata  out  8  frame byte.
REQ-015 m_axis_tvalid  out  1  byte valid.
REQ-016 m_axis_tready  in  1  downstream accepts byte.
REQ-017 m_axis_tlast  out  1  marks the final byte of a frame.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frames_sent  out  32  count of completed frames.

Function
REQ-020 The FSM SHALL have states IDLE, HEADER, PAYLOAD and GAP.
REQ-021 IDLE with fifo_rd_valid=1: assert fifo_rd_enable for exactly that cycle, latch all command fields, load the byte counter to 0, go to HEADER.
REQ-022 fifo_rd_enable SHALL never be asserted outside IDLE, nor for two consecutive cycles.
REQ-023 Effective length L SHALL be MIN_SIZE if size<MIN_SIZE, MAX_SIZE if size>MAX_SIZE, otherwise size.
REQ-024 L SHALL be computed from the latched size at pop time, using 11-bit unsigned comparison.
REQ-025 The first byte SHALL appear with m_axis_tvalid=1 on the cycle after the pop.
REQ-026 HEADER SHALL emit 14 bytes, each field LSB-first: d_mac[7:0]..d_mac[47:40], s_mac[7:0]..s_mac[47:40], ethertype[7:0], ethertype[15:8].
REQ-027 PAYLOAD SHALL emit the latched payload byte L-14 times.
REQ-028 The byte counter SHALL advance only on handshake (tvalid & tready).
REQ-029 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL be held stable.
REQ-030 m_axis_tvalid SHALL stay continuously high from the first byte through the last byte of a frame; there are no bubbles.
REQ-031 m_axis_tlast SHALL be 1 only on byte index L-1.
REQ-032 On handshake of the tlast byte: frames_sent increments, wrapping 0xFFFFFFFF->0, and tvalid drops the next cycle.
REQ-033 After the tlast handshake, go to GAP when IFG_CYCLES>0, otherwise to IDLE.
REQ-034 GAP SHALL last exactly IFG_CYCLES cycles with tvalid=0, then return to IDLE.
REQ-035 GAP SHALL not pop the FIFO even when fifo_rd_valid=1.
REQ-036 Command fields SHALL be ignored outside the pop cycle; input changes mid-frame SHALL not affect the frame in flight.
REQ-037 With a continuously valid FIFO and tready=1, frame period SHALL be L+1+IFG_CYCLES cycles: 1 pop cycle, L byte cycles, IFG_CYCLES gap cycles.

Reset
REQ-038 Asserting rst SHALL immediately force state IDLE.
REQ-039 During rst, fifo_rd_enable=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0 and frames_sent=0.
REQ-040 rst mid-frame SHALL abandon the frame without a tlast and without incrementing frames_sent.
REQ-041 rst mid-frame SHALL not re-pop the abandoned command.
REQ-042 After rst deasserts, the first pop SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-043 size=64, d_mac=48'h563412BC9A78 (wire order 78 9A BC 12 34 56), payload=8'h1A, tready=1 -> bytes 78 9A BC 12 34 56, then s_mac bytes, then 08 00, then fifty 1A; tlast on byte 63; frames_sent=1.
REQ-044 size=20 -> exactly 60 bytes with tlast on byte 59; size=2000 -> exactly 1514 bytes.
REQ-045 tready toggled 1,0,0,1 repeatedly -> byte stream identical to the tready=1 case; tdata stable across every stall.
REQ-046 Three back-to-back commands with size=64, IFG_CYCLES=12 -> pops 77 cycles apart; tvalid low for exactly 13 cycles between frames; frames_sent=3.
REQ-047 rst pulsed at byte 30 of a 64-byte frame -> tvalid=0 immediately; frames_sent=0; next command emitted whole and correct.
REQ-048 frames_sent preset to 0xFFFFFFFF by force, one frame sent -> frames_sent=0.
